// File: rtl/draw_bullet.sv
// Single-projectile overlay stage: arms on a fire request, launches from the barrel on the
// next frame boundary, steps once per frame, retires at the screen edge, then cools down.
module draw_bullet #(
    parameter int          H_RES           = 800,
    parameter int          V_RES           = 600,
    parameter int          BULLET_SIZE     = 4,
    parameter int          SPEED           = 4,
    parameter int          COOLDOWN_FRAMES = 30,
    parameter logic [11:0] BULLET_COLOR    = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        select_in,
    input  logic [9:0]  xpos_tank_in,
    input  logic [9:0]  ypos_tank_in,
    input  logic [1:0]  direction_tank_in,
    input  logic        fire,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [9:0]  xpos_bullet_out,
    output logic [9:0]  ypos_bullet_out,
    output logic        bullet_active,
    output logic        bullet_done
);

    // state    | meaning
    // IDLE     | no bullet, accepting fire requests
    // ARMED    | spawn latched, waiting for the next frame tick
    // FLYING   | bullet on screen, one step per frame tick
    // COOLDOWN | bullet retired, counting frames before re-arming
    typedef enum logic [1:0] {IDLE, ARMED, FLYING, COOLDOWN} state_t;

    localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [10:0] S          = 11'(BULLET_SIZE);
    localparam logic [10:0] SPD        = 11'(SPEED);
    localparam logic [10:0] HR         = 11'(H_RES);
    localparam logic [10:0] VR         = 11'(V_RES);
    localparam logic [10:0] TANK_LONG  = 11'd64;
    localparam logic [10:0] BARREL_OFS = 11'd22;

    state_t          state;
    logic            vblnk_d;
    logic            tick;
    logic [10:0]     latch_x;
    logic [10:0]     latch_y;
    logic [1:0]      latch_dir;
    logic [10:0]     xb;
    logic [10:0]     yb;
    logic [CD_W-1:0] cd_cnt;

    logic [10:0] tank_x;
    logic [10:0] tank_y;
    logic [10:0] spawn_x;
    logic [10:0] spawn_y;
    logic        spawn_ok;
    logic [10:0] step_x;
    logic [10:0] step_y;
    logic        exit_screen;
    logic [10:0] vcount_ext;
    logic        hit;

    assign tick       = vblnk_in & ~vblnk_d;
    assign tank_x     = {1'b0, xpos_tank_in};
    assign tank_y     = {1'b0, ypos_tank_in};
    assign vcount_ext = {1'b0, vcount_in};

    assign xpos_bullet_out = xb[9:0];
    assign ypos_bullet_out = yb[9:0];

    always_comb begin
        spawn_x  = tank_x;
        spawn_y  = tank_y;
        spawn_ok = 1'b0;
        case (direction_tank_in)
            2'd0: begin
                spawn_x  = tank_x + BARREL_OFS;
                spawn_y  = tank_y - S;
                spawn_ok = (tank_y >= S);
            end
            2'd1: begin
                spawn_x  = tank_x + BARREL_OFS;
                spawn_y  = tank_y + TANK_LONG;
                spawn_ok = (tank_y + TANK_LONG + S <= VR);
            end
            2'd2: begin
                spawn_x  = tank_x - S;
                spawn_y  = tank_y + BARREL_OFS;
                spawn_ok = (tank_x >= S);
            end
            default: begin
                spawn_x  = tank_x + TANK_LONG;
                spawn_y  = tank_y + BARREL_OFS;
                spawn_ok = (tank_x + TANK_LONG + S <= HR);
            end
        endcase
    end

    // Exit test looks at the step that would be taken, so the bullet never draws off-screen.
    always_comb begin
        step_x      = xb;
        step_y      = yb;
        exit_screen = 1'b0;
        case (latch_dir)
            2'd0: begin
                step_y      = yb - SPD;
                exit_screen = (yb < SPD);
            end
            2'd1: begin
                step_y      = yb + SPD;
                exit_screen = (yb + SPD + S > VR);
            end
            2'd2: begin
                step_x      = xb - SPD;
                exit_screen = (xb < SPD);
            end
            default: begin
                step_x      = xb + SPD;
                exit_screen = (xb + SPD + S > HR);
            end
        endcase
    end

    assign hit = (state == FLYING) && !hblnk_in && !vblnk_in &&
                 (hcount_in >= xb) && (hcount_in < xb + S) &&
                 (vcount_ext >= yb) && (vcount_ext < yb + S);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            vblnk_d       <= 1'b0;
            latch_x       <= '0;
            latch_y       <= '0;
            latch_dir     <= '0;
            xb            <= '0;
            yb            <= '0;
            cd_cnt        <= '0;
            hcount_out    <= '0;
            vcount_out    <= '0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
            hblnk_out     <= 1'b0;
            vblnk_out     <= 1'b0;
            rgb_out       <= '0;
            bullet_active <= 1'b0;
            bullet_done   <= 1'b0;
        end else begin
            vblnk_d     <= vblnk_in;
            hcount_out  <= hcount_in;
            vcount_out  <= vcount_in;
            hsync_out   <= hsync_in;
            vsync_out   <= vsync_in;
            hblnk_out   <= hblnk_in;
            vblnk_out   <= vblnk_in;
            rgb_out     <= hit ? BULLET_COLOR : rgb_in;
            bullet_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire && select_in && spawn_ok) begin
                        latch_x   <= spawn_x;
                        latch_y   <= spawn_y;
                        latch_dir <= direction_tank_in;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (tick) begin
                        xb            <= latch_x;
                        yb            <= latch_y;
                        bullet_active <= 1'b1;
                        state         <= FLYING;
                    end
                end
                FLYING: begin
                    if (tick) begin
                        if (exit_screen) begin
                            bullet_done   <= 1'b1;
                            bullet_active <= 1'b0;
                            cd_cnt        <= CD_LOAD;
                            state         <= COOLDOWN;
                        end else begin
                            xb <= step_x;
                            yb <= step_y;
                        end
                    end
                end
                COOLDOWN: begin
                    if (tick) begin
                        if (cd_cnt == '0) state <= IDLE;
                        else              cd_cnt <= cd_cnt - CD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/draw_bullet.md
# draw_bullet

Downstream neighbour of the tank drawing stage in the VGA overlay chain. It consumes the delayed timing, the tank position, the tank direction and `select` produced by the tank stage. It owns one projectile: it latches a fire request, spawns the bullet at the barrel on the next frame boundary, moves it once per frame and retires it at the screen edge. It overlays the bullet onto the incoming RGB stream, which goes on to the next overlay stage.

## Interface
Parameters:
- `H_RES`, 800, visible width in pixels
- `V_RES`, 600, visible height in pixels
- `BULLET_SIZE`, 4, bullet edge length in pixels (square)
- `SPEED`, 4, pixels moved per frame
- `COOLDOWN_FRAMES`, 30, frames of cooldown after a bullet retires
- `BULLET_COLOR`, 12'hF00, bullet RGB

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, asynchronous, active-high
- `hcount_in`  in  11  horizontal counter
- `vcount_in`  in  10  vertical counter
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  sync and blanking
- `rgb_in`  in  12  upstream pixel
- `select_in`  in  1  this player's tank is active
- `xpos_tank_in`, `ypos_tank_in`  in  10 each  tank top-left corner
- `direction_tank_in`  in  2  0 = up, 1 = down, 2 = left, 3 = right
- `fire`  in  1  fire request, sampled every cycle
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  widths as inputs  timing delayed by 1 cycle
- `rgb_out`  out  12  overlaid pixel
- `xpos_bullet_out`, `ypos_bullet_out`  out  10 each  bullet top-left corner
- `bullet_active`  out  1  high in FLYING
- `bullet_done`  out  1  one-cycle pulse when the bullet retires

## Operation
- Frame tick: `tick = vblnk_in & ~vblnk_d`, where `vblnk_d` is `vblnk_in` registered. Bullet position changes only on a tick, so it never changes mid-frame.
- Tank footprint: directions 0/1 occupy 48 wide × 64 tall; directions 2/3 occupy 64 wide × 48 tall.
- Spawn position from latched tank (x, y), with S = `BULLET_SIZE`:
  - up: (x+22, y−S)
  - down: (x+22, y+64)
  - left: (x−S, y+22)
  - right: (x+64, y+22)
- Spawn legality: up needs y ≥ S; left needs x ≥ S; down needs y+64+S ≤ V_RES; right needs x+64+S ≤ H_RES.
- All spawn and boundary arithmetic is evaluated at 11 bits, with no wrap.
- States:
  - IDLE: when `fire & select_in` and the spawn is legal, latch the spawn position and direction and go to ARMED. An illegal spawn is ignored and the block stays in IDLE.
  - ARMED: on tick, load the bullet position from the latch and go to FLYING. No movement on this tick.
  - FLYING: on tick, when the next step leaves the screen, pulse `bullet_done`, load the cooldown counter with COOLDOWN_FRAMES and go to COOLDOWN. Otherwise step by SPEED.
    - up exits when y < SPEED
    - down exits when y+SPEED+S > V_RES
    - left exits when x < SPEED
    - right exits when x+SPEED+S > H_RES
  - COOLDOWN: on tick, go to IDLE when the counter is 0, else decrement.
- `fire` in ARMED, FLYING or COOLDOWN is ignored; requests are not queued.
- `fire` coinciding with a tick in IDLE: go to ARMED. The spawn happens on the following tick.
- Tank movement after the fire request does not affect the bullet.
- Overlay: `rgb_out` = BULLET_COLOR when all of the following hold, else `rgb_in`, registered:
  - state is FLYING
  - hcount_in ∈ [xb, xb+S) and vcount_in ∈ [yb, yb+S)
  - hblnk_in = 0 and vblnk_in = 0

## Timing
- Single 1-cycle pipeline: every `*_out` timing signal and `rgb_out` is its input registered once.
- `xpos_bullet_out` and `ypos_bullet_out` update in the cycle after a tick.
- `bullet_active` is registered and asserts in the cycle after the ARMED→FLYING tick.
- `bullet_done` is high for exactly one cycle, the cycle after the retiring tick.
- Reset (asynchronous, active-high) takes effect immediately, including mid-flight or mid-cooldown:
  - state → IDLE
  - all outputs → 0
  - `vblnk_d` and cooldown counter → 0
  - latch → 0
- The first tick after reset release is a normal rising-edge detection.

## Test plan
- Reset: assert `rst` between clock edges → all outputs 0 immediately, including `rgb_out` = 0 and `bullet_active` = 0.
- Right shot: tank (100,200), dir 3, `select_in`=1, one-cycle `fire` →
  - first tick: bullet (164,222), `bullet_active`=1
  - next tick: (168,222)
  - pixel (168,222) unblanked → `rgb_out`=F00 one cycle later
  - pixel (172,222) → `rgb_out`=`rgb_in`
- Up edge: tank y=8, dir 0 → spawn y=4 → next tick y=0 → next tick `bullet_done` pulses once, `bullet_active`=0.
- Cooldown/ignore:
  - `fire` during FLYING and during COOLDOWN causes no spawn.
  - With default COOLDOWN_FRAMES, IDLE is reached on the 31st tick after retirement; a `fire` then arms normally.
- Illegal spawn: dir 0 with tank y=2 → stays IDLE.
- Gating: `fire` with `select_in`=0 → stays IDLE.
- Tick/fire collision: `fire` on the tick cycle → ARMED; spawn on the following tick only; `bullet_active` low until then.
